// File: rtl/muldiv_ctrl_if.sv
// Bus bundle between EX/writeback/engines and the muldiv issue controller.
// slave: controller view; master: environment (EX, writeback, engines) view.
interface muldiv_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_a;
  logic [XLEN-1:0]   req_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;

  logic              mul_start;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic              mul_valid;
  logic [2*XLEN-1:0] mul_prod;

  logic              div_start;
  logic [XLEN-1:0]   div_a;
  logic [XLEN-1:0]   div_b;
  logic              div_valid;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   div_rem;

  modport slave (
    input  req_valid, req_funct3, req_a, req_b, rsp_ready,
    input  mul_valid, mul_prod, div_valid, div_quo, div_rem,
    output req_ready, rsp_valid, rsp_data,
    output mul_start, mul_a, mul_b, div_start, div_a, div_b
  );

  modport master (
    output req_valid, req_funct3, req_a, req_b, rsp_ready,
    output mul_valid, mul_prod, div_valid, div_quo, div_rem,
    input  req_ready, rsp_valid, rsp_data,
    input  mul_start, mul_a, mul_b, div_start, div_a, div_b
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Issue/sequencing controller for the M-extension multiplier and divider engines.
// Latches one op, feeds unsigned magnitudes to one engine, applies sign fix-up and the
// RISC-V divide corner cases, and holds the result until writeback takes it.
// Optional MULDIV_FUSE_EN: keeps the last fixed-up product so a repeated multiply with the
// same operands and signedness class completes without restarting the multiplier.
module muldiv_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  muldiv_ctrl_if.slave  bus,
  input  logic          flush_i,
  output logic          busy_o
);

  localparam logic [2:0] F3Mul    = 3'd0;
  localparam logic [2:0] F3Mulh   = 3'd1;
  localparam logic [2:0] F3Mulhsu = 3'd2;
  localparam logic [2:0] F3Mulhu  = 3'd3;
  localparam logic [2:0] F3Div    = 3'd4;
  localparam logic [2:0] F3Divu   = 3'd5;
  localparam logic [2:0] F3Rem    = 3'd6;
  localparam logic [2:0] F3Remu   = 3'd7;

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMulWait, StDivWait, StResp, StDrain} state_e;

  state_e            r_state, w_state_d;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a_mag, r_b_mag, r_rsp_data;
  logic              r_neg, r_mul_start, r_div_start;

  logic              w_accept, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
  logic              w_div_zero, w_div_ovf, w_corner, w_fast;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_corner_data, w_fast_data;
  logic [2*XLEN-1:0] w_mul_fixed;
  logic [XLEN-1:0]   w_mul_data, w_div_raw, w_div_data;
  logic              w_mul_done, w_div_done;

  // Decode the presented op: signedness, magnitudes, result sign and divide corner cases.
  always_comb begin
    w_accept   = bus.req_valid & bus.req_ready & ~flush_i;
    w_is_div   = bus.req_funct3[2];
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    unique case (bus.req_funct3)
      F3Mul, F3Mulh, F3Div, F3Rem: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      F3Mulhsu: w_a_signed = 1'b1;
      F3Mulhu, F3Divu, F3Remu: ;
      default: ;
    endcase
    w_a_neg = w_a_signed & bus.req_a[XLEN-1];
    w_b_neg = w_b_signed & bus.req_b[XLEN-1];
    w_a_mag = w_a_neg ? -bus.req_a : bus.req_a;
    w_b_mag = w_b_neg ? -bus.req_b : bus.req_b;
    unique case (bus.req_funct3)
      F3Mul, F3Mulh, F3Div: w_neg = w_a_neg ^ w_b_neg;
      F3Mulhsu, F3Rem:      w_neg = w_a_neg;
      default:              w_neg = 1'b0;
    endcase
    w_div_zero = w_is_div & (bus.req_b == '0);
    // Signed overflow only applies to DIV/REM (funct3[0] clear).
    w_div_ovf  = w_is_div & ~bus.req_funct3[0] & (bus.req_a == MinInt) & (bus.req_b == '1);
    w_corner   = w_div_zero | w_div_ovf;
    if (w_div_zero) begin
      w_corner_data = bus.req_funct3[1] ? bus.req_a : '1;
    end else begin
      w_corner_data = bus.req_funct3[1] ? '0 : bus.req_a;
    end
  end

  // Fix up engine results into the architectural value.
  always_comb begin
    w_mul_fixed = r_neg ? -bus.mul_prod : bus.mul_prod;
    w_mul_data  = (r_op == F3Mul) ? w_mul_fixed[XLEN-1:0] : w_mul_fixed[2*XLEN-1:XLEN];
    w_div_raw   = r_op[1] ? bus.div_rem : bus.div_quo;
    w_div_data  = r_neg ? -w_div_raw : w_div_raw;
    w_mul_done  = (r_state == StMulWait) & bus.mul_valid & ~flush_i;
    w_div_done  = (r_state == StDivWait) & bus.div_valid & ~flush_i;
  end

`ifdef MULDIV_FUSE_EN
  logic [1:0]        w_cls, r_cls, r_fz_cls;
  logic              w_fuse_hit, r_fz_valid;
  logic [XLEN-1:0]   w_fuse_data, r_a, r_b, r_fz_a, r_fz_b;
  logic [2*XLEN-1:0] r_fz_prod;

  // Signedness class of the presented multiply and lookup in the product store.
  always_comb begin
    unique case (bus.req_funct3)
      F3Mulhsu: w_cls = 2'd1;
      F3Mulhu:  w_cls = 2'd2;
      default:  w_cls = 2'd0;
    endcase
    w_fuse_hit  = r_fz_valid & ~w_is_div & (bus.req_a == r_fz_a) & (bus.req_b == r_fz_b) &
                  (w_cls == r_fz_cls);
    w_fuse_data = (bus.req_funct3 == F3Mul) ? r_fz_prod[XLEN-1:0] : r_fz_prod[2*XLEN-1:XLEN];
    w_fast      = w_corner | w_fuse_hit;
    w_fast_data = w_corner ? w_corner_data : w_fuse_data;
  end

  // Product store: filled on multiply completion, dropped on any aborted engine op.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_a        <= '0;
      r_b        <= '0;
      r_cls      <= '0;
      r_fz_valid <= 1'b0;
      r_fz_prod  <= '0;
      r_fz_a     <= '0;
      r_fz_b     <= '0;
      r_fz_cls   <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= bus.req_a;
        r_b   <= bus.req_b;
        r_cls <= w_cls;
      end
      if (w_mul_done) begin
        r_fz_valid <= 1'b1;
        r_fz_prod  <= w_mul_fixed;
        r_fz_a     <= r_a;
        r_fz_b     <= r_b;
        r_fz_cls   <= r_cls;
      end
      if ((flush_i & (r_state == StMulWait)) | (r_state == StDrain)) begin
        r_fz_valid <= 1'b0;
      end
    end
  end
`else
  // Without the store only the divide corner cases bypass the engines.
  always_comb begin
    w_fast      = w_corner;
    w_fast_data = w_corner_data;
  end
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; flush takes priority over every other event.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_fast)        w_state_d = StResp;
          else if (w_is_div) w_state_d = StDivWait;
          else               w_state_d = StMulWait;
        end
      end
      StMulWait: begin
        // An engine finishing in the flush cycle is already idle, so no drain is needed.
        if (flush_i)            w_state_d = bus.mul_valid ? StIdle : StDrain;
        else if (bus.mul_valid) w_state_d = StResp;
      end
      StDivWait: begin
        if (flush_i)            w_state_d = bus.div_valid ? StIdle : StDrain;
        else if (bus.div_valid) w_state_d = StResp;
      end
      StResp: begin
        if (flush_i | bus.rsp_ready) w_state_d = StIdle;
      end
      StDrain: begin
        if (r_op[2] ? bus.div_valid : bus.mul_valid) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Operand latch, one-cycle start pulses and result register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_op        <= '0;
      r_a_mag     <= '0;
      r_b_mag     <= '0;
      r_neg       <= 1'b0;
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_mul_start <= w_accept & ~w_fast & ~w_is_div;
      r_div_start <= w_accept & ~w_fast & w_is_div;
      if (w_accept) begin
        r_op    <= bus.req_funct3;
        r_a_mag <= w_a_mag;
        r_b_mag <= w_b_mag;
        r_neg   <= w_neg;
      end
      if (w_accept & w_fast) begin
        r_rsp_data <= w_fast_data;
      end else if (w_mul_done) begin
        r_rsp_data <= w_mul_data;
      end else if (w_div_done) begin
        r_rsp_data <= w_div_data;
      end
    end
  end

  assign bus.req_ready = rst_ni & (r_state == StIdle);
  assign bus.rsp_valid = (r_state == StResp);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.mul_start = r_mul_start;
  assign bus.mul_a     = r_a_mag;
  assign bus.mul_b     = r_b_mag;
  assign bus.div_start = r_div_start;
  assign bus.div_a     = r_a_mag;
  assign bus.div_b     = r_b_mag;
  assign busy_o        = (r_state != StIdle);

endmodule
